// File: rtl/window3x3_gen_pkg.sv
// Shared widths, window geometry and slot packing helpers for the 3x3 window path.
`ifndef BIT_WIDTH_VH
`define BIT_WIDTH_VH
`define IMG_DATA_WIDTH 8
`define IMG_DATA_MATRIX_WIDTH (9*`IMG_DATA_WIDTH)
`define WIN_DIM 3
// Slot 8 is the top-left pixel, slot 0 the bottom-right pixel.
`define WIN_SLOT(r, c) ((`WIN_DIM*`WIN_DIM - 1) - ((r)*`WIN_DIM + (c)))
`endif

package window3x3_gen_pkg;

  localparam int unsigned DATA_W   = `IMG_DATA_WIDTH;
  localparam int unsigned MATRIX_W = `IMG_DATA_MATRIX_WIDTH;
  localparam int unsigned WIN_DIM  = `WIN_DIM;

  typedef logic [DATA_W-1:0] pixel_t;

  // Bit offset of window pixel (r, c) inside the packed matrix.
  function automatic int unsigned slot_lsb(input int unsigned r, input int unsigned c);
    return (`WIN_SLOT(r, c)) * DATA_W;
  endfunction

endpackage

// File: rtl/window3x3_gen_line_buffer.sv
// Single-port row buffer: combinational read at addr, write of the new value on the same edge.
module line_buffer
  import window3x3_gen_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  pixel_t            wdata,
  output pixel_t            rdata
);

  pixel_t mem [DEPTH];

  // Old contents are visible until the write edge, giving read-before-write.
  assign rdata = mem[addr];

  // Contents are deliberately not reset; the row counter masks stale data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window3x3_gen.sv
// Raster-order pixel stream to packed 3x3 neighbourhood generator.
module window3x3_gen
  import window3x3_gen_pkg::*;
#(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8,
  parameter int unsigned COL_W = $clog2(IMG_W),
  parameter int unsigned ROW_W = $clog2(IMG_H)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic [MATRIX_W-1:0] inMatrix,
  output logic                out_valid,
  output logic [ROW_W-1:0]    out_row,
  output logic [COL_W-1:0]    out_col,
  output logic                frame_done
);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             accept;
  logic             col_last;
  logic             row_last;
  logic             win_complete;

  pixel_t top;
  pixel_t mid;
  pixel_t entering    [WIN_DIM];
  pixel_t win         [WIN_DIM][WIN_DIM];
  pixel_t win_next    [WIN_DIM][WIN_DIM];
  logic [MATRIX_W-1:0] matrix_next;

  assign accept       = ena & in_valid;
  assign col_last     = (col == COL_W'(IMG_W - 1));
  assign row_last     = (row == ROW_W'(IMG_H - 1));
  assign win_complete = (row >= ROW_W'(2)) && (col >= COL_W'(2));

  // lb0 holds the previous row, lb1 the row before it; lb1 is refilled from lb0.
  line_buffer #(.DEPTH(IMG_W), .ADDR_W(COL_W)) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (in_data),
    .rdata (mid)
  );

  line_buffer #(.DEPTH(IMG_W), .ADDR_W(COL_W)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (mid),
    .rdata (top)
  );

  // Raster position of the pixel currently being offered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Window after this accept: shift left, new {top,mid,bot} column on the right.
  // The output is packed from this next-state view so the window leaves on the accept edge.
  always_comb begin
    entering[0] = top;
    entering[1] = mid;
    entering[2] = in_data;
    matrix_next = '0;
    for (int unsigned r = 0; r < WIN_DIM; r++) begin
      win_next[r][0] = win[r][1];
      win_next[r][1] = win[r][2];
      win_next[r][2] = entering[r];
      for (int unsigned c = 0; c < WIN_DIM; c++) begin
        matrix_next[slot_lsb(r, c) +: DATA_W] = win_next[r][c];
      end
    end
  end

  // Window shift registers advance only on accepted pixels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < WIN_DIM; r++) begin
        for (int unsigned c = 0; c < WIN_DIM; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      win <= win_next;
    end
  end

  // Output registers: one-cycle pulses, matrix and centre position hold between windows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inMatrix   <= '0;
      out_valid  <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= accept && win_complete;
      frame_done <= accept && col_last && row_last;
      if (accept && win_complete) begin
        inMatrix <= matrix_next;
        out_row  <= row - ROW_W'(1);
        out_col  <= col - COL_W'(1);
      end
    end
  end

endmodule
